// File: rtl/t04_screen_rx.sv
// t04_screen_rx: 8080-style screen bus receiver decoding CASET/PASET/RAMWR into pixels.
// Optional macro T04_SCREEN_RX_SWRESET_EN: command 0x01 restores windows and clears errOdd.
module t04_screen_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int SCREEN_W    = 320,
   parameter int SCREEN_H    = 240
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        screenCsx,
   input  logic        screenDcx,
   input  logic        screenWrx,
   input  logic [7:0]  screenData,
   output logic        cmdValid,
   output logic [7:0]  cmdByte,
   output logic        pixValid,
   output logic [15:0] pixX,
   output logic [15:0] pixY,
   output logic [15:0] pixColor,
   output logic        frameDone,
   output logic        errOdd
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CASET = 3'd1;
   localparam logic [2:0] S_PASET = 3'd2;
   localparam logic [2:0] S_HI    = 3'd3;
   localparam logic [2:0] S_LO    = 3'd4;

   localparam logic [15:0] X_END_RST = 16'(SCREEN_W - 1);
   localparam logic [15:0] Y_END_RST = 16'(SCREEN_H - 1);

   logic [SYNC_STAGES-1:0]       csx_q;
   logic [SYNC_STAGES-1:0]       dcx_q;
   logic [SYNC_STAGES-1:0]       wrx_q;
   logic [SYNC_STAGES-1:0][7:0]  data_q;
   logic                         wrx_d;
   logic                         csx_d;

   logic       csx_s;
   logic       dcx_s;
   logic       wrx_s;
   logic [7:0] data_s;
   logic       wr_evt;
   logic       cs_end;

   logic [2:0]  state;
   logic [1:0]  idx;
   logic [23:0] shadow;
   logic [7:0]  hi_byte;
   logic [15:0] x_start;
   logic [15:0] x_end;
   logic [15:0] y_start;
   logic [15:0] y_end;
   logic [15:0] cx;
   logic [15:0] cy;
   logic [15:0] nx;
   logic [15:0] ny;

   assign csx_s  = csx_q[SYNC_STAGES-1];
   assign dcx_s  = dcx_q[SYNC_STAGES-1];
   assign wrx_s  = wrx_q[SYNC_STAGES-1];
   assign data_s = data_q[SYNC_STAGES-1];
   assign wr_evt = wrx_s & ~wrx_d & ~csx_s;
   assign cs_end = csx_s & ~csx_d;

   // Bus idles with CSX/WRX high; resetting the syncs high means a
   // strobe already high at release never looks like a fresh edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         csx_q  <= '1;
         dcx_q  <= '0;
         wrx_q  <= '1;
         data_q <= '0;
         wrx_d  <= 1'b1;
         csx_d  <= 1'b1;
      end else begin
         csx_q  <= {csx_q[SYNC_STAGES-2:0], screenCsx};
         dcx_q  <= {dcx_q[SYNC_STAGES-2:0], screenDcx};
         wrx_q  <= {wrx_q[SYNC_STAGES-2:0], screenWrx};
         data_q <= {data_q[SYNC_STAGES-2:0], screenData};
         wrx_d  <= wrx_s;
         csx_d  <= csx_s;
      end
   end

   always_comb begin
      nx = cx + 16'd1;
      ny = cy;
      if (cx == x_end) begin
         nx = x_start;
         ny = (cy == y_end) ? y_start : cy + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         idx       <= 2'd0;
         shadow    <= '0;
         hi_byte   <= '0;
         x_start   <= '0;
         x_end     <= X_END_RST;
         y_start   <= '0;
         y_end     <= Y_END_RST;
         cx        <= '0;
         cy        <= '0;
         cmdValid  <= 1'b0;
         cmdByte   <= '0;
         pixValid  <= 1'b0;
         pixX      <= '0;
         pixY      <= '0;
         pixColor  <= '0;
         frameDone <= 1'b0;
         errOdd    <= 1'b0;
      end else begin
         cmdValid  <= 1'b0;
         pixValid  <= 1'b0;
         frameDone <= 1'b0;
         if (cs_end) begin
            if (state == S_LO) errOdd <= 1'b1;
            state <= S_IDLE;
            idx   <= 2'd0;
         end else if (wr_evt && !dcx_s) begin
            cmdValid <= 1'b1;
            cmdByte  <= data_s;
            idx      <= 2'd0;
            if (state == S_LO) errOdd <= 1'b1;
            unique case (1'b1)
               (data_s == 8'h2A): state <= S_CASET;
               (data_s == 8'h2B): state <= S_PASET;
               (data_s == 8'h2C): begin
                  state <= S_HI;
                  cx    <= x_start;
                  cy    <= y_start;
               end
               default: state <= S_IDLE;
            endcase
`ifdef T04_SCREEN_RX_SWRESET_EN
            if (data_s == 8'h01) begin
               x_start <= '0;
               x_end   <= X_END_RST;
               y_start <= '0;
               y_end   <= Y_END_RST;
               errOdd  <= 1'b0;
            end
`endif
         end else if (wr_evt) begin
            case (state)
               S_CASET, S_PASET: begin
                  if (idx == 2'd3) begin
                     if (state == S_CASET) begin
                        x_start <= shadow[23:8];
                        x_end   <= {shadow[7:0], data_s};
                     end else begin
                        y_start <= shadow[23:8];
                        y_end   <= {shadow[7:0], data_s};
                     end
                     state <= S_IDLE;
                     idx   <= 2'd0;
                  end else begin
                     shadow <= {shadow[15:0], data_s};
                     idx    <= idx + 2'd1;
                  end
               end
               S_HI: begin
                  hi_byte <= data_s;
                  state   <= S_LO;
               end
               S_LO: begin
                  pixValid  <= 1'b1;
                  pixColor  <= {hi_byte, data_s};
                  pixX      <= cx;
                  pixY      <= cy;
                  frameDone <= (cx == x_end) && (cy == y_end);
                  cx        <= nx;
                  cy        <= ny;
                  state     <= S_HI;
               end
               S_IDLE: state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_t04_screen_rx.sv
// tb_t04_screen_rx: scoreboard bench for t04_screen_rx.
// Pixel and command pulses are popped against queued expectations.
`timescale 1ns/1ps
module tb_t04_screen_rx;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        screenCsx = 1'b1;
   logic        screenDcx = 1'b1;
   logic        screenWrx = 1'b1;
   logic [7:0]  screenData = 8'h00;
   logic        cmdValid;
   logic [7:0]  cmdByte;
   logic        pixValid;
   logic [15:0] pixX;
   logic [15:0] pixY;
   logic [15:0] pixColor;
   logic        frameDone;
   logic        errOdd;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] c;
      logic        fd;
   } pix_t;

   pix_t       pq[$];
   logic [7:0] cq[$];
   int errors = 0;
   int checks = 0;
   int pix_cnt = 0;
   int pc;
   logic [15:0] mxs, mxe, mys, mye, mcx, mcy;
   logic [15:0] xs7[7] = '{16'd10, 16'd11, 16'd12, 16'd10, 16'd11, 16'd12, 16'd10};
   logic [15:0] ys7[7] = '{16'd5, 16'd5, 16'd5, 16'd6, 16'd6, 16'd6, 16'd5};

   t04_screen_rx #(.SYNC_STAGES(2), .SCREEN_W(320), .SCREEN_H(240)) dut (
      .clk(clk), .nrst(nrst),
      .screenCsx(screenCsx), .screenDcx(screenDcx),
      .screenWrx(screenWrx), .screenData(screenData),
      .cmdValid(cmdValid), .cmdByte(cmdByte),
      .pixValid(pixValid), .pixX(pixX), .pixY(pixY),
      .pixColor(pixColor), .frameDone(frameDone), .errOdd(errOdd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nrst) begin
         if (pixValid) begin
            pix_cnt++;
            if (pq.size() == 0) check("pix_extra", 32'd1, 32'd0);
            else begin
               pix_t e;
               e = pq.pop_front();
               check("pix_x", 32'(pixX), 32'(e.x));
               check("pix_y", 32'(pixY), 32'(e.y));
               check("pix_color", 32'(pixColor), 32'(e.c));
               check("frame_done", 32'(frameDone), 32'(e.fd));
            end
         end
         if (cmdValid) begin
            if (cq.size() == 0) check("cmd_extra", 32'd1, 32'd0);
            else check("cmd_byte", 32'(cmdByte), 32'(cq.pop_front()));
         end
      end
   end

   task automatic wr(input logic dc, input logic [7:0] b, input bit lat = 1'b0);
      screenCsx  = 1'b0;
      screenDcx  = dc;
      screenData = b;
      screenWrx  = 1'b0;
      repeat (4) @(negedge clk);
      screenWrx = 1'b1;
      if (lat) begin
         repeat (2) @(negedge clk);
         check("lat_early", 32'(cmdValid | pixValid), 32'd0);
         @(negedge clk);
         check("lat_pulse", 32'(cmdValid | pixValid), 32'd1);
         @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic cmd(input logic [7:0] b);
      cq.push_back(b);
      if (b == 8'h2C) begin
         mcx = mxs;
         mcy = mys;
      end
`ifdef T04_SCREEN_RX_SWRESET_EN
      if (b == 8'h01) begin
         mxs = 0; mxe = 319; mys = 0; mye = 239;
      end
`endif
      wr(1'b0, b);
   endtask

   task automatic win(input logic [7:0] c, input logic [15:0] s,
                      input logic [15:0] e);
      cmd(c);
      wr(1'b1, s[15:8]);
      wr(1'b1, s[7:0]);
      wr(1'b1, e[15:8]);
      wr(1'b1, e[7:0]);
      if (c == 8'h2A) begin
         mxs = s; mxe = e;
      end else begin
         mys = s; mye = e;
      end
   endtask

   task automatic exp_pix(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] c, input logic fd);
      pix_t p;
      p.x = x; p.y = y; p.c = c; p.fd = fd;
      pq.push_back(p);
   endtask

   task automatic raw_pix(input logic [15:0] c);
      wr(1'b1, c[15:8]);
      wr(1'b1, c[7:0]);
   endtask

   // Reference cursor walk for long streams.
   task automatic m_pix(input logic [15:0] c);
      exp_pix(mcx, mcy, c, (mcx == mxe) && (mcy == mye));
      if (mcx == mxe) begin
         mcx = mxs;
         mcy = (mcy == mye) ? mys : mcy + 16'd1;
      end else begin
         mcx = mcx + 16'd1;
      end
      raw_pix(c);
   endtask

   task automatic do_reset();
      #3 nrst = 1'b0;
      mxs = 0; mxe = 319; mys = 0; mye = 239; mcx = 0; mcy = 0;
      screenCsx = 1'b1; screenWrx = 1'b1; screenDcx = 1'b1;
      #1;
      check("rst_cmdvalid", 32'(cmdValid), 32'd0);
      check("rst_cmdbyte", 32'(cmdByte), 32'd0);
      check("rst_pixvalid", 32'(pixValid), 32'd0);
      check("rst_pixx", 32'(pixX), 32'd0);
      check("rst_pixy", 32'(pixY), 32'd0);
      check("rst_color", 32'(pixColor), 32'd0);
      check("rst_frame", 32'(frameDone), 32'd0);
      check("rst_errodd", 32'(errOdd), 32'd0);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      do_reset();

      cq.push_back(8'h2A);
      wr(1'b0, 8'h2A, 1'b1);
      wr(1'b1, 8'h00); wr(1'b1, 8'h0A); wr(1'b1, 8'h00); wr(1'b1, 8'h0C);
      mxs = 10; mxe = 12;
      check("caset_cmdbyte", 32'(cmdByte), 32'h2A);

      win(8'h2B, 16'd5, 16'd6);
      cmd(8'h2C);
      for (int i = 0; i < 7; i++) begin
         exp_pix(xs7[i], ys7[i], 16'hF800, i == 5);
         raw_pix(16'hF800);
      end
      check("ramwr_count", 32'(pix_cnt), 32'd7);
      check("ramwr_errodd", 32'(errOdd), 32'd0);

      cmd(8'h2C);
      exp_pix(16'd10, 16'd5, 16'h1234, 1'b0);
      raw_pix(16'h1234);
      wr(1'b1, 8'h56);
      cmd(8'h00);
      check("odd_errodd", 32'(errOdd), 32'd1);
      check("odd_cmdbyte", 32'(cmdByte), 32'h00);
      check("odd_count", 32'(pix_cnt), 32'd8);

      cmd(8'h2A);
      wr(1'b1, 8'h00); wr(1'b1, 8'h01);
      screenCsx = 1'b1;
      repeat (6) @(negedge clk);
      wr(1'b1, 8'h00); wr(1'b1, 8'h03);
      cmd(8'h2C);
      exp_pix(16'd10, 16'd5, 16'hAAAA, 1'b0);
      raw_pix(16'hAAAA);
      exp_pix(16'd11, 16'd5, 16'h5555, 1'b0);
      raw_pix(16'h5555);
      win(8'h2A, 16'd1, 16'd2);
      cmd(8'h2C);
      exp_pix(16'd1, 16'd5, 16'h0001, 1'b0); raw_pix(16'h0001);
      exp_pix(16'd2, 16'd5, 16'h0002, 1'b0); raw_pix(16'h0002);
      exp_pix(16'd1, 16'd6, 16'h0003, 1'b0); raw_pix(16'h0003);
      exp_pix(16'd2, 16'd6, 16'h0004, 1'b1); raw_pix(16'h0004);
      check("abort_errodd", 32'(errOdd), 32'd1);

      win(8'h2A, 16'd5, 16'd6);
      cmd(8'h01);
      cmd(8'h2C);
`ifdef T04_SCREEN_RX_SWRESET_EN
      check("swrst_errodd", 32'(errOdd), 32'd0);
      exp_pix(16'd0, 16'd0, 16'h0F0F, 1'b0);
`else
      check("swrst_errodd", 32'(errOdd), 32'd1);
      exp_pix(16'd5, 16'd5, 16'h0F0F, 1'b0);
`endif
      raw_pix(16'h0F0F);

      cmd(8'h2C);
      wr(1'b1, 8'hC3);
      check("pre_rst_cmdbyte", 32'(cmdByte), 32'h2C);
      do_reset();
      pc = pix_cnt;
      wr(1'b1, 8'h3C);
      repeat (4) @(negedge clk);
      check("lo_only_nopix", 32'(pix_cnt), 32'(pc));

      win(8'h2B, 16'd0, 16'd0);
      cmd(8'h2C);
      pc = pix_cnt;
      for (int i = 0; i < 321; i++) m_pix(16'(i * 7 + 1));
      check("xstream_count", 32'(pix_cnt - pc), 32'd321);

      do_reset();
      win(8'h2A, 16'd0, 16'd0);
      cmd(8'h2C);
      pc = pix_cnt;
      for (int i = 0; i < 241; i++) m_pix(16'(i * 13 + 5));
      check("ystream_count", 32'(pix_cnt - pc), 32'd241);

      repeat (10) @(negedge clk);
      check("pix_left", 32'(pq.size()), 32'd0);
      check("cmd_left", 32'(cq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
